// File: rtl/flit_arb_pkg.sv
// Shared types and default constants for the flit arbiter.
// The optional per-source statistics are enabled by defining FLIT_ARB_STATS_EN.
package flit_arb_pkg;

  localparam int unsigned FLIT_WIDTH = 11;
  localparam int unsigned ARB_N      = 4;
  localparam int unsigned ARB_BURST  = 4;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Round-robin search: first set request at or after ptr, wrapping modulo N.
// Part of flit_arbiter (optional stats enabled by defining FLIT_ARB_STATS_EN).
module rr_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] sel,
  output logic          any
);

  // One spare bit so ptr + i never overflows before the modulo fold.
  logic [IW:0] idx;

  always_comb begin
    sel = '0;
    any = 1'b0;
    idx = '0;
    for (int i = 0; i < int'(N); i++) begin
      idx = {1'b0, ptr} + (IW + 1)'(i);
      if (idx >= (IW + 1)'(N)) begin
        idx = idx - (IW + 1)'(N);
      end
      if (!any && req[idx[IW-1:0]]) begin
        any = 1'b1;
        sel = idx[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/flit_arbiter.sv
// N-input round-robin flit arbiter with burst locking and a registered output stage.
// Define FLIT_ARB_STATS_EN to add the per-source grant_cnt output counters.
module flit_arbiter
  import flit_arb_pkg::*;
#(
  parameter int unsigned WIDTH = FLIT_WIDTH,
  parameter int unsigned N     = ARB_N,
  parameter int unsigned BURST = ARB_BURST
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N-1:0]           in_valid,
  input  logic [N*WIDTH-1:0]     in_data,
  output logic [N-1:0]           in_ready,
  output logic                   out_valid,
  output logic [WIDTH-1:0]       out_data,
  input  logic                   out_ready,
  output logic [$clog2(N)-1:0]   grant_id
`ifdef FLIT_ARB_STATS_EN
  ,
  output logic [N-1:0][15:0]     grant_cnt
`endif
);

  localparam int unsigned IW = $clog2(N);
  localparam int unsigned CW = 8;

  arb_state_e    state_q, state_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [CW-1:0] count_q, count_d;

  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  logic [IW-1:0]    grant_id_q;

  logic          can_load;
  logic          pick_any;
  logic [IW-1:0] pick_sel;
  logic [IW-1:0] src;
  logic [N-1:0]  ready;
  logic          xfer;

  function automatic logic [IW-1:0] next_port(input logic [IW-1:0] p);
    return (p == IW'(N - 1)) ? '0 : p + 1'b1;
  endfunction

  rr_pick #(
    .N  (N),
    .IW (IW)
  ) u_rr_pick (
    .req (in_valid),
    .ptr (rr_ptr_q),
    .sel (pick_sel),
    .any (pick_any)
  );

  // Readiness is gated by rst_n so in_ready drops the instant reset asserts.
  always_comb begin
    can_load = !out_valid_q || out_ready;
    src      = (state_q == LOCK) ? owner_q : pick_sel;
    ready    = '0;
    if (rst_n && ((state_q == LOCK) || pick_any)) begin
      ready[src] = can_load;
    end
    xfer = ready[src] && in_valid[src];
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    count_d  = count_q;
    rr_ptr_d = rr_ptr_q;
    unique case (state_q)
      IDLE: begin
        if (xfer) begin
          if (BURST > 1) begin
            state_d = LOCK;
            owner_d = pick_sel;
            count_d = CW'(1);
          end else begin
            rr_ptr_d = next_port(pick_sel);
          end
        end
      end
      LOCK: begin
        // Under backpressure everything holds; otherwise either continue or release.
        if (can_load) begin
          if (xfer && (count_q != CW'(BURST - 1))) begin
            count_d = count_q + 1'b1;
          end else begin
            state_d  = IDLE;
            count_d  = '0;
            rr_ptr_d = next_port(owner_q);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      grant_id_q  <= '0;
    end else if (xfer) begin
      out_valid_q <= 1'b1;
      out_data_q  <= in_data[int'(src) * WIDTH +: WIDTH];
      grant_id_q  <= src;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign in_ready  = ready;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign grant_id  = grant_id_q;

`ifdef FLIT_ARB_STATS_EN
  logic [N-1:0][15:0] grant_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt_q <= '0;
    end else if (out_valid_q && out_ready && (grant_cnt_q[grant_id_q] != 16'hFFFF)) begin
      grant_cnt_q[grant_id_q] <= grant_cnt_q[grant_id_q] + 16'd1;
    end
  end

  assign grant_cnt = grant_cnt_q;
`endif

endmodule

// File: tb/tb_flit_arbiter.sv
// Self-checking bench for flit_arbiter: directed vector table, corner sequences and
// randomized traffic against a reference model (two DUTs: BURST=4 and BURST=1).
module tb_flit_arbiter;

  localparam int unsigned W  = 11;
  localparam int unsigned NP = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NP-1:0] in_valid;
  logic [NP*W-1:0] in_data;
  logic          out_ready;

  logic [NP-1:0] rdy0, rdy1;
  logic          ov0, ov1;
  logic [W-1:0]  od0, od1;
  logic [1:0]    gid0, gid1;
`ifdef FLIT_ARB_STATS_EN
  logic [NP-1:0][15:0] gc0, gc1;
`endif

  always #5 clk = ~clk;

  flit_arbiter #(.WIDTH(W), .N(NP), .BURST(4)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (rdy0),
    .out_valid (ov0),
    .out_data  (od0),
    .out_ready (out_ready),
    .grant_id  (gid0)
`ifdef FLIT_ARB_STATS_EN
    ,
    .grant_cnt (gc0)
`endif
  );

  flit_arbiter #(.WIDTH(W), .N(NP), .BURST(1)) u_dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (rdy1),
    .out_valid (ov1),
    .out_data  (od1),
    .out_ready (out_ready),
    .grant_id  (gid1)
`ifdef FLIT_ARB_STATS_EN
    ,
    .grant_cnt (gc1)
`endif
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: owner < 0 means free arbitration; left = flits still allowed in grant.
  int          m_burst[2];
  int          m_owner[2];
  int          m_left[2];
  int          m_ptr[2];
  bit          m_ov[2];
  logic [W-1:0] m_od[2];
  int          m_gid[2];

  task automatic m_reset();
    for (int k = 0; k < 2; k++) begin
      m_owner[k] = -1;
      m_left[k]  = 0;
      m_ptr[k]   = 0;
      m_ov[k]    = 1'b0;
      m_od[k]    = '0;
      m_gid[k]   = 0;
    end
  endtask

  function automatic int m_cand(input int k);
    if (m_owner[k] >= 0) return m_owner[k];
    for (int i = 0; i < int'(NP); i++) begin
      if (in_valid[(m_ptr[k] + i) % NP]) return (m_ptr[k] + i) % NP;
    end
    return -1;
  endfunction

  function automatic logic [NP-1:0] m_ready(input int k);
    int c;
    c = m_cand(k);
    if (c < 0 || (m_ov[k] && !out_ready)) return '0;
    return NP'(1 << c);
  endfunction

  task automatic m_step(input int k);
    int c;
    bit can, x;
    can = !m_ov[k] || out_ready;
    c   = m_cand(k);
    x   = (c >= 0) && can && in_valid[c];
    if (x) begin
      m_ov[k]  = 1'b1;
      m_od[k]  = in_data[c*W +: W];
      m_gid[k] = c;
    end else if (out_ready) begin
      m_ov[k] = 1'b0;
    end
    if (m_owner[k] < 0) begin
      if (x) begin
        m_left[k] = m_burst[k] - 1;
        if (m_left[k] > 0) m_owner[k] = c;
        else m_ptr[k] = (c + 1) % NP;
      end
    end else if (can) begin
      if (x) m_left[k]--;
      if (!x || m_left[k] == 0) begin
        m_ptr[k]   = (m_owner[k] + 1) % NP;
        m_owner[k] = -1;
        m_left[k]  = 0;
      end
    end
  endtask

  // Asserts reset mid-cycle, checks the asynchronous clear, releases after the next edge.
  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n     = 1'b0;
    in_valid  = '1;
    out_ready = 1'b1;
    #2;
    chk("rst_out_valid", 32'(ov0), 32'(0));
    chk("rst_out_data", 32'(od0), 32'(0));
    chk("rst_grant_id", 32'(gid0), 32'(0));
    chk("rst_in_ready", 32'(rdy0), 32'(0));
    chk("rst_in_ready_b1", 32'(rdy1), 32'(0));
    chk("rst_out_valid_b1", 32'(ov1), 32'(0));
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    in_valid = '0;
    m_reset();
  endtask

  task automatic cyc_check_ready(input string name, input logic [NP-1:0] act,
                                 input logic [NP-1:0] exp);
    chk(name, 32'(act), 32'(exp));
  endtask

  typedef struct {
    logic [NP-1:0] valid;
    logic          ordy;
    logic [NP-1:0] exp_rdy;
    logic          exp_ov;
    logic [1:0]    exp_gid;
  } vec_t;

  vec_t tbl[12];
  int   seq[NP];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = '0;
    in_data   = '0;
    out_ready = 1'b0;
    m_burst[0] = 4;
    m_burst[1] = 1;

    tbl[0]  = '{4'hF, 1'b1, 4'b0001, 1'b1, 2'd0};
    tbl[1]  = '{4'hF, 1'b1, 4'b0001, 1'b1, 2'd0};
    tbl[2]  = '{4'hF, 1'b1, 4'b0001, 1'b1, 2'd0};
    tbl[3]  = '{4'hF, 1'b1, 4'b0001, 1'b1, 2'd0};
    tbl[4]  = '{4'hF, 1'b1, 4'b0010, 1'b1, 2'd1};
    tbl[5]  = '{4'hF, 1'b1, 4'b0010, 1'b1, 2'd1};
    tbl[6]  = '{4'hF, 1'b1, 4'b0010, 1'b1, 2'd1};
    tbl[7]  = '{4'hF, 1'b1, 4'b0010, 1'b1, 2'd1};
    tbl[8]  = '{4'hF, 1'b1, 4'b0100, 1'b1, 2'd2};
    tbl[9]  = '{4'hF, 1'b1, 4'b0100, 1'b1, 2'd2};
    tbl[10] = '{4'hF, 1'b1, 4'b0100, 1'b1, 2'd2};
    tbl[11] = '{4'hF, 1'b1, 4'b0100, 1'b1, 2'd2};

    // All ports valid, BURST=4: four flits per source in order.
    do_reset();
    for (int p = 0; p < int'(NP); p++) seq[p] = 0;
    for (int i = 0; i < 12; i++) begin
      in_valid  = tbl[i].valid;
      out_ready = tbl[i].ordy;
      for (int p = 0; p < int'(NP); p++) in_data[p*W +: W] = 11'((p << 8) | seq[p]);
      @(negedge clk);
      chk($sformatf("tbl%0d_in_ready", i), 32'(rdy0), 32'(tbl[i].exp_rdy));
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d_out_valid", i), 32'(ov0), 32'(tbl[i].exp_ov));
      chk($sformatf("tbl%0d_grant_id", i), 32'(gid0), 32'(tbl[i].exp_gid));
      chk($sformatf("tbl%0d_out_data", i), 32'(od0),
          32'((int'(tbl[i].exp_gid) << 8) | seq[tbl[i].exp_gid]));
      seq[tbl[i].exp_gid]++;
    end

    // Single flit from port 2 held under 5 cycles of backpressure.
    do_reset();
    in_valid  = 4'b0100;
    in_data[2*W +: W] = 11'h155;
    out_ready = 1'b0;
    @(negedge clk);
    cyc_check_ready("stall_first_ready", rdy0, 4'b0100);
    @(posedge clk);
    #1;
    chk("stall_load_valid", 32'(ov0), 32'(1));
    chk("stall_load_data", 32'(od0), 32'h155);
    in_data[2*W +: W] = 11'h2AA;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      cyc_check_ready($sformatf("stall%0d_in_ready", i), rdy0, 4'b0000);
      @(posedge clk);
      #1;
      chk($sformatf("stall%0d_out_valid", i), 32'(ov0), 32'(1));
      chk($sformatf("stall%0d_out_data", i), 32'(od0), 32'h155);
      chk($sformatf("stall%0d_grant_id", i), 32'(gid0), 32'(2));
    end
    out_ready = 1'b1;
    in_valid  = 4'b0000;
    @(negedge clk);
    cyc_check_ready("stall_owner_ready", rdy0, 4'b0100);
    @(posedge clk);
    #1;
    chk("stall_drain_valid", 32'(ov0), 32'(0));
    in_valid = 4'b1111;
    @(negedge clk);
    cyc_check_ready("stall_next_ptr3", rdy0, 4'b1000);
    @(posedge clk);
    #1;
    chk("stall_next_gid", 32'(gid0), 32'(3));

    // Port 1 drops valid at count 2; arbitration resumes from port 2.
    do_reset();
    in_valid  = 4'b0010;
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("drop_gid%0d", i), 32'(gid0), 32'(1));
    end
    in_valid = 4'b0000;
    @(negedge clk);
    cyc_check_ready("drop_owner_ready", rdy0, 4'b0010);
    @(posedge clk);
    #1;
    chk("drop_out_valid", 32'(ov0), 32'(0));
    in_valid = 4'b1010;
    @(negedge clk);
    cyc_check_ready("drop_next_ready", rdy0, 4'b1000);
    @(posedge clk);
    #1;
    chk("drop_next_gid", 32'(gid0), 32'(3));
    chk("drop_next_valid", 32'(ov0), 32'(1));

    // BURST=1 instance alternates between ports 0 and 3.
    do_reset();
    in_valid  = 4'b1001;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      cyc_check_ready($sformatf("b1_ready%0d", i), rdy1, (i % 2) ? 4'b1000 : 4'b0001);
      @(posedge clk);
      #1;
      chk($sformatf("b1_gid%0d", i), 32'(gid1), (i % 2) ? 32'(3) : 32'(0));
      chk($sformatf("b1_valid%0d", i), 32'(ov1), 32'(1));
    end

    // Reset in the middle of a locked, stalled burst.
    do_reset();
    in_valid  = 4'b0110;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_lock_gid", 32'(gid0), 32'(1));
    @(posedge clk);
    #1;
    chk("midrst_held_valid", 32'(ov0), 32'(1));
    do_reset();
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    @(negedge clk);
    cyc_check_ready("midrst_first_ready", rdy0, 4'b0001);
    @(posedge clk);
    #1;
    chk("midrst_first_gid", 32'(gid0), 32'(0));
    chk("midrst_first_valid", 32'(ov0), 32'(1));

`ifdef FLIT_ARB_STATS_EN
    // Ten flits from port 1, all accepted downstream.
    do_reset();
    for (int p = 0; p < int'(NP); p++) chk($sformatf("stats_rst%0d", p), 32'(gc0[p]), 32'(0));
    in_valid  = 4'b0010;
    out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    in_valid = 4'b0000;
    repeat (3) @(posedge clk);
    #1;
    for (int p = 0; p < int'(NP); p++) begin
      chk($sformatf("stats_cnt%0d", p), 32'(gc0[p]), (p == 1) ? 32'(10) : 32'(0));
      chk($sformatf("stats_b1_cnt%0d", p), 32'(gc1[p]), (p == 1) ? 32'(10) : 32'(0));
    end
`endif

    // Randomized traffic against the model for both burst settings.
    do_reset();
    for (int c = 0; c < 800; c++) begin
      in_valid  = NP'($urandom) & NP'($urandom | $urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      for (int p = 0; p < int'(NP); p++) in_data[p*W +: W] = 11'($urandom);
      @(negedge clk);
      chk($sformatf("rnd%0d_ready_b4", c), 32'(rdy0), 32'(m_ready(0)));
      chk($sformatf("rnd%0d_ready_b1", c), 32'(rdy1), 32'(m_ready(1)));
      @(posedge clk);
      m_step(0);
      m_step(1);
      #1;
      chk($sformatf("rnd%0d_valid_b4", c), 32'(ov0), 32'(m_ov[0]));
      chk($sformatf("rnd%0d_valid_b1", c), 32'(ov1), 32'(m_ov[1]));
      if (m_ov[0]) begin
        chk($sformatf("rnd%0d_data_b4", c), 32'(od0), 32'(m_od[0]));
        chk($sformatf("rnd%0d_gid_b4", c), 32'(gid0), 32'(m_gid[0]));
      end
      if (m_ov[1]) begin
        chk($sformatf("rnd%0d_data_b1", c), 32'(od1), 32'(m_od[1]));
        chk($sformatf("rnd%0d_gid_b1", c), 32'(gid1), 32'(m_gid[1]));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
